// File: rtl/mem_row_splitter_pkg.sv
// mem_row_splitter_pkg: index-width helpers and the response pipeline stage type
// shared by the memory-tile row splitter.
package mem_row_splitter_pkg;

   // Wide enough for any practical macro column; the top slices the low RowW bits.
   localparam int unsigned MaxRowW = 16;

   typedef struct packed {
      logic               valid;
      logic [MaxRowW-1:0] row;
      logic               we;
      logic               err;
   } resp_stage_t;

   function automatic int unsigned row_w(input int unsigned num_rows);
      return (num_rows > 1) ? $clog2(num_rows) : 1;
   endfunction

   function automatic int unsigned col_w(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/mem_row_splitter_resp_pipe.sv
// mem_resp_pipe: fixed-depth, never-stalling shift register carrying
// {valid, row, we, err} alongside the SRAM read latency.
module mem_resp_pipe
   import mem_row_splitter_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  resp_stage_t stage_i,
   output resp_stage_t stage_o,
   output logic        busy_o
);

   resp_stage_t stage_q [Depth];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= stage_i;
         for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < Depth; i++) busy_o = busy_o | stage_q[i].valid;
   end

   assign stage_o = stage_q[Depth-1];

endmodule

// File: rtl/mem_row_splitter.sv
// mem_row_splitter: steers one bank port onto a column of single-port SRAM
// macros and returns the addressed macro's read data in order.
module mem_row_splitter
   import mem_row_splitter_pkg::*;
#(
   parameter int unsigned AddrWidth     = 20,
   parameter int unsigned DataWidth     = 256,
   parameter int unsigned NumWords      = 512,
   parameter int unsigned NumRows       = 64,
   parameter int unsigned RowLsb        = 14,
   parameter int unsigned SramLatency   = 1,
   parameter bit          OutReg        = 1'b0,
   parameter int unsigned IdleThreshold = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                req_i,
   output logic                                gnt_o,
   input  logic [AddrWidth-1:0]                addr_i,
   input  logic                                we_i,
   input  logic [DataWidth-1:0]                wdata_i,
   input  logic [DataWidth/8-1:0]              be_i,
   output logic                                rvalid_o,
   output logic [DataWidth-1:0]                rdata_o,
   output logic [NumRows-1:0]                  sram_req_o,
   output logic                                sram_we_o,
   output logic [$clog2(NumWords)-1:0]         sram_addr_o,
   output logic [DataWidth-1:0]                sram_wdata_o,
   output logic [DataWidth/8-1:0]              sram_be_o,
   input  logic [NumRows-1:0][DataWidth-1:0]   sram_rdata_i,
   input  logic                                clear_err_i,
   output logic                                err_o,
   output logic                                idle_o
);

   localparam int unsigned RowW  = row_w(NumRows);
   localparam int unsigned ColW  = col_w(DataWidth);
   localparam int unsigned WordW = $clog2(NumWords);
   localparam int unsigned CntW  = $clog2(IdleThreshold + 1);

   logic [RowW-1:0] row;
   logic            hi_err;
   logic            req_err;

   assign row = addr_i[RowLsb +: RowW];

   generate
      if (RowLsb + RowW < AddrWidth) begin : g_hi
         assign hi_err = |addr_i[AddrWidth-1:RowLsb+RowW];
      end else begin : g_no_hi
         assign hi_err = 1'b0;
      end
   endgenerate

   // Non-power-of-two columns leave row codes with no macro behind them.
   assign req_err = hi_err || (32'(row) >= NumRows);

   assign gnt_o        = req_i;
   assign sram_req_o   = (req_i && !req_err) ? (NumRows'(1) << row) : '0;
   assign sram_we_o    = we_i && req_i && !req_err;
   assign sram_addr_o  = addr_i[ColW +: WordW];
   assign sram_wdata_o = wdata_i;
   assign sram_be_o    = be_i;

   resp_stage_t     stage_in;
   resp_stage_t     stage_last;
   logic            pipe_busy;
   logic [RowW-1:0] rd_row;
   logic            rvalid_d;
   logic [DataWidth-1:0] rdata_d;

   assign stage_in = '{valid: req_i, row: MaxRowW'(row), we: we_i, err: req_err};

   mem_resp_pipe #(
      .Depth(SramLatency)
   ) u_resp_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .stage_i(stage_in),
      .stage_o(stage_last),
      .busy_o (pipe_busy)
   );

   assign rd_row   = stage_last.row[RowW-1:0];
   assign rvalid_d = stage_last.valid;
   assign rdata_d  = (stage_last.err || stage_last.we) ? '0 : sram_rdata_i[rd_row];

   generate
      if (OutReg) begin : g_out_reg
         logic                 rvalid_q;
         logic [DataWidth-1:0] rdata_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               rvalid_q <= 1'b0;
               rdata_q  <= '0;
            end else begin
               rvalid_q <= rvalid_d;
               rdata_q  <= rdata_d;
            end
         end
         assign rvalid_o = rvalid_q;
         assign rdata_o  = rdata_q;
      end else begin : g_out_comb
         assign rvalid_o = rvalid_d;
         assign rdata_o  = rdata_d;
      end
   endgenerate

   logic            err_q, err_d;
   logic            idle_q, idle_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // A new error outranks a simultaneous clear so it is never lost.
   always_comb begin
      err_d  = (req_i && req_err) ? 1'b1 : (clear_err_i ? 1'b0 : err_q);
      cnt_d  = (req_i || pipe_busy || rvalid_o) ? '0 :
               ((cnt_q == CntW'(IdleThreshold)) ? cnt_q : cnt_q + CntW'(1));
      idle_d = (cnt_d == CntW'(IdleThreshold));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q  <= 1'b0;
         cnt_q  <= '0;
         idle_q <= 1'b0;
      end else begin
         err_q  <= err_d;
         cnt_q  <= cnt_d;
         idle_q <= idle_d;
      end
   end

   assign err_o  = err_q;
   assign idle_o = idle_q;

   logic unused_bits;
   assign unused_bits = ^{addr_i, stage_last.row};

endmodule

// File: tb/tb_mem_row_splitter.sv
// tb_mem_row_splitter: directed and random traffic against a 3-macro column,
// with a scoreboard checking every response's data and arrival cycle.
module tb_mem_row_splitter;

   localparam int AW  = 20;
   localparam int DW  = 256;
   localparam int NW  = 512;
   localparam int NR  = 3;
   localparam int BEW = DW / 8;
   localparam int LAT = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_i = 1'b0, we_i = 1'b0, clear_err_i = 1'b0;
   logic [AW-1:0]     addr_i = '0;
   logic [DW-1:0]     wdata_i = '0;
   logic [BEW-1:0]    be_i = '0;
   logic              gnt_o, rvalid_o, sram_we_o, err_o, idle_o;
   logic [DW-1:0]     rdata_o, sram_wdata_o;
   logic [NR-1:0]     sram_req_o;
   logic [8:0]        sram_addr_o;
   logic [BEW-1:0]    sram_be_o;
   logic [NR-1:0][DW-1:0] sram_rdata;

   always #5 clk = ~clk;

   mem_row_splitter #(
      .AddrWidth(AW), .DataWidth(DW), .NumWords(NW), .NumRows(NR), .RowLsb(14),
      .SramLatency(2), .OutReg(1'b1), .IdleThreshold(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
      .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
      .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata),
      .clear_err_i(clear_err_i), .err_o(err_o), .idle_o(idle_o)
   );

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] smem [NR][NW];
   logic [DW-1:0] rmem [NR][NW];
   logic [DW-1:0] d1 [NR];
   int            vectors = 0, miscompares = 0, cyc = 0, rv_seen = 0, last_rv = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(input int r, input int w);
      if (r == 0 && w == 0) return DW'(8'h10);
      if (r == 1 && w == 0) return DW'(8'h11);
      if (r == 2 && w == 0) return DW'(8'h12);
      if (r == 0 && w == 5) return DW'(8'h13);
      return {8{32'(r * 4096 + w)}};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Two-cycle SRAM macro model: array read, then output register.
   initial begin
      for (int r = 0; r < NR; r++) begin
         d1[r] = '0;
         for (int w = 0; w < NW; w++) smem[r][w] = init_val(r, w);
      end
      forever begin
         @(posedge clk);
         for (int r = 0; r < NR; r++) begin
            sram_rdata[r] <= d1[r];
            if (sram_req_o[r]) begin
               if (sram_we_o) begin
                  for (int b = 0; b < BEW; b++)
                     if (sram_be_o[b]) smem[r][sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
               end else begin
                  d1[r] <= smem[r][sram_addr_o];
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rvalid_o) begin
            rv_seen++;
            last_rv = cyc;
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_rvalid: got rdata %h at cycle %0d, expected no response", rdata_o, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rdata", rdata_o, e.data);
               check("resp_cycle", DW'(cyc), DW'(e.due));
            end
         end
      end
   end

   task automatic drive(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [BEW-1:0] be, input logic clr);
      int   r, w;
      logic bad;
      exp_t e;
      @(posedge clk);
      #1;
      req_i = req; we_i = we; addr_i = addr; wdata_i = wd; be_i = be; clear_err_i = clr;
      if (req) begin
         r   = int'(addr[15:14]);
         w   = int'(addr[13:5]);
         bad = (r >= NR) || (addr[19:16] != 4'h0);
         e.data = '0;
         e.due  = cyc + LAT;
         if (!bad && we)
            for (int b = 0; b < BEW; b++) if (be[b]) rmem[r][w][8*b +: 8] = wd[8*b +: 8];
         if (!bad && !we) e.data = rmem[r][w];
         sb.push_back(e);
      end
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic drain();
      idle_cycle();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("drained", DW'(sb.size()), '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] wd;
      logic [AW-1:0] a;
      int            rv0;
      for (int r = 0; r < NR; r++)
         for (int w = 0; w < NW; w++) rmem[r][w] = init_val(r, w);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rvalid", DW'(rvalid_o), '0);
      check("rst_rdata", rdata_o, '0);
      check("rst_err", DW'(err_o), '0);
      check("rst_idle", DW'(idle_o), '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // write then read row 2, word 1
      drive(1'b1, 1'b1, 20'h08020, {32{8'hA5}}, '1, 1'b0);
      @(negedge clk);
      check("wr_sel", DW'(sram_req_o), DW'(3'b100));
      check("wr_we", DW'(sram_we_o), DW'(1'b1));
      check("wr_word", DW'(sram_addr_o), DW'(9'd1));
      check("wr_gnt", DW'(gnt_o), DW'(1'b1));
      drive(1'b1, 1'b0, 20'h08020, '0, '0, 1'b0);
      @(negedge clk);
      check("rd_sel", DW'(sram_req_o), DW'(3'b100));
      check("rd_we", DW'(sram_we_o), '0);
      drain();

      // back-to-back reads across rows
      drive(1'b1, 1'b0, 20'h00000, '0, '0, 1'b0);
      drive(1'b1, 1'b0, 20'h04000, '0, '0, 1'b0);
      drive(1'b1, 1'b0, 20'h08000, '0, '0, 1'b0);
      drive(1'b1, 1'b0, 20'h000A0, '0, '0, 1'b0);
      drain();

      // out of range: missing macro, then a high address bit with clear
      drive(1'b1, 1'b0, 20'h0C000, '0, '0, 1'b0);
      @(negedge clk);
      check("oor_sel", DW'(sram_req_o), '0);
      check("oor_err_pre", DW'(err_o), '0);
      idle_cycle();
      @(negedge clk);
      check("oor_err_set", DW'(err_o), DW'(1'b1));
      drive(1'b1, 1'b1, 20'h10000, '1, '1, 1'b1);
      @(negedge clk);
      check("hi_sel", DW'(sram_req_o), '0);
      check("hi_we", DW'(sram_we_o), '0);
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      @(negedge clk);
      check("set_wins", DW'(err_o), DW'(1'b1));
      idle_cycle();
      @(negedge clk);
      check("err_cleared", DW'(err_o), '0);
      drain();

      // idle hint
      for (int i = 0; i < 20 && !idle_o; i++) @(negedge clk);
      check("idle_delay", DW'(cyc - last_rv), DW'(5));
      drive(1'b1, 1'b0, 20'h04000, '0, '0, 1'b0);
      @(negedge clk);
      check("idle_hold", DW'(idle_o), DW'(1'b1));
      idle_cycle();
      @(negedge clk);
      check("idle_drop", DW'(idle_o), '0);
      drain();

      // reset with reads in flight
      drive(1'b1, 1'b0, 20'h0C000, '0, '0, 1'b0);
      repeat (3) idle_cycle();
      drive(1'b1, 1'b0, 20'h00000, '0, '0, 1'b0);
      drive(1'b1, 1'b0, 20'h04000, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req_i = 1'b0;
      sb.delete();
      rv0 = rv_seen;
      @(negedge clk);
      check("mid_rst_err", DW'(err_o), '0);
      check("mid_rst_idle", DW'(idle_o), '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_rvalids", DW'(rv_seen - rv0), '0);
      check("post_rst_err", DW'(err_o), '0);

      // random traffic including out-of-range addresses
      for (int n = 0; n < 10000; ) begin
         if ($urandom_range(0, 4) == 0) begin
            idle_cycle();
         end else begin
            a = {4'h0, 2'($urandom_range(0, 3)), 9'($urandom_range(0, 7)), 5'($urandom)};
            if ($urandom_range(0, 15) == 0) a[16 + $urandom_range(0, 3)] = 1'b1;
            for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
            drive(1'b1, 1'($urandom), a, wd, BEW'({$urandom, $urandom}), 1'($urandom));
            n++;
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
